spi_reg_responder: RTL

//  SPI slave-side command responder: decodes master frames into reads/writes of a local

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_edge_sync.sv | 27 ++
 rtl/spi_reg_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register responder: FSM state encoding,
// command-byte layout and the default register address width.
package spi_pkg;

  // Default register address width (NUM_REGS = 2**ADDR_W).
  localparam int ADDR_W = 3;

  // Bit of the command byte that selects read (1) or write (0).
  localparam int CMD_RW_BIT = 7;

  // Frame FSM encoding, also driven out on the debug state port.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;  // waiting for a chip-select falling edge
  localparam state_t ST_CMD  = 2'd1;  // shifting the command byte
  localparam state_t ST_DATA = 2'd2;  // shifting the data byte(s)
  localparam state_t ST_DONE = 2'd3;  // extra bytes: ignored until CS rises

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer with rising/falling edge detection in the clk domain.
// The third flop holds the previous synchronized value for edge compare.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] metastability stage, [1] synchronized level, [2] previous level
  logic [2:0] sync_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {3{RST_VAL}};
    else     sync_q <= {sync_q[1:0], d_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  =  sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_reg_responder.sv
// SPI slave command responder: decodes {rw, addr} + data frames into reads
// and writes of a local 8-bit register bank. SCLK/CS/MOSI are oversampled in
// the clk domain (clk must be at least 8x SCLK).
// Optional feature macro: SPI_REG_AUTOINC_EN -- when defined, bytes after the
// first data byte continue as a burst with the address incrementing (wrapping);
// when undefined, extra bytes are ignored in the DONE state.
//
// Handshake note: host_we is a single-cycle strobe with no back-pressure; it
// commits on the clk edge where it is high. wr_stb/frame_err are single-cycle
// pulses the cycle after the event; wr_addr holds the last SPI write address.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int         ADDR_W    = spi_pkg::ADDR_W,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter logic [7:0] ID_BYTE   = 8'hA5,
  localparam int        NUM_REGS  = 2**ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SPI_SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [7:0]            host_wdata,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  busy,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  frame_err,
  output logic [1:0]            dbg_state
);

  // ---------------------------------------------------------------------------
  // Bus synchronization
  // ---------------------------------------------------------------------------
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [1:0] mosi_q;
  logic       mosi_s;

  spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (SPI_SCLK),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // CS resets to the "active" level: if CS is really high a rising edge is
  // seen shortly after reset, which arms the FSM; if it is low mid-frame no
  // edge is seen and the frame is ignored until CS goes high.
  spi_edge_sync #(.RST_VAL(1'b0)) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (CS),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  // MOSI goes through the same two-flop depth as SCLK so data and edge align.
  always_ff @(posedge clk) begin
    if (rst) mosi_q <= 2'b00;
    else     mosi_q <= {mosi_q[0], MOSI};
  end
  assign mosi_s = mosi_q[1];

  // Leading edge = transition away from CPOL, i.e. arriving at level ~CPOL.
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  assign sclk_edge   = sclk_rise | sclk_fall;
  assign lead_edge   = sclk_edge & (sclk_lvl != CPOL);
  assign trail_edge  = sclk_edge & (sclk_lvl == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  // ---------------------------------------------------------------------------
  // Frame FSM and shifters
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          rx_q, rx_d, rx_shift;
  logic [7:0]          tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                armed_q, armed_d;
  logic                frame_err_d;
  logic                spi_we;
  logic                wr_stb_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                frame_err_q;
  logic [7:0]          regs_q [NUM_REGS];

`ifdef SPI_REG_AUTOINC_EN
  logic [ADDR_W-1:0]   addr_inc;
  assign addr_inc = addr_q + ADDR_W'(1);
`endif

  // Next-state logic: frame start/stop, bit shifting and byte-end decisions.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    armed_d     = armed_q | cs_rise;
    frame_err_d = 1'b0;
    spi_we      = 1'b0;
    rx_shift    = {rx_q[6:0], mosi_s};

    if (state_q == ST_IDLE) begin
      if (cs_fall && armed_q) begin
        state_d   = ST_CMD;
        bit_cnt_d = 3'd0;
        rx_d      = 8'h00;
        if (CPHA) begin
          // First bit goes out on the first (leading) shift edge.
          tx_d   = ID_BYTE;
          miso_d = 1'b0;
        end else begin
          // First bit must be valid before the first (leading) sample edge.
          tx_d   = {ID_BYTE[6:0], 1'b0};
          miso_d = ID_BYTE[7];
        end
      end
    end else if (cs_rise) begin
      // End of frame: a partial byte is dropped and flagged.
      state_d     = ST_IDLE;
      miso_d      = 1'b0;
      frame_err_d = (bit_cnt_q != 3'd0);
      bit_cnt_d   = 3'd0;
    end else begin
      if (shift_edge) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (sample_edge) begin
        rx_d      = rx_shift;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == ST_CMD) begin
            rw_d    = rx_shift[CMD_RW_BIT];
            addr_d  = rx_shift[ADDR_W-1:0];
            state_d = ST_DATA;
            tx_d    = rx_shift[CMD_RW_BIT] ? regs_q[rx_shift[ADDR_W-1:0]] : 8'h00;
          end else if (state_q == ST_DATA) begin
            spi_we = ~rw_q;
`ifdef SPI_REG_AUTOINC_EN
            addr_d = addr_inc;
            tx_d   = rw_q ? regs_q[addr_inc] : 8'h00;
`else
            state_d = ST_DONE;
            tx_d    = 8'h00;
`endif
          end
        end
      end
    end
  end

  // Frame state registers and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      miso_q      <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      armed_q     <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      armed_q     <= armed_d;
      wr_stb_q    <= spi_we;
      frame_err_q <= frame_err_d;
      if (spi_we) wr_addr_q <= addr_q;
    end
  end

  // Register bank: the SPI write is applied last so it wins an address clash.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      if (host_we) regs_q[host_addr] <= host_wdata;
      if (spi_we)  regs_q[addr_q]    <= rx_shift;
    end
  end

  // Flatten the bank onto the output bus, reg[i] at bits 8*i+7:8*i.
  always_comb begin
    regs = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[8*i +: 8] = regs_q[i];
  end

  assign MISO      = miso_q;
  assign busy      = armed_q & ~cs_lvl;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

endmodule
